// File: rtl/dac_loader_pkg.sv
// Shared constants, FSM encoding and the configuration record of the DAC pattern loader.
// The optional acknowledge channel is enabled with DAC_LOADER_ACK_EN.
package dac_loader_pkg;

  localparam int unsigned TABLE_BYTES = 10;
  localparam int unsigned TABLE_W     = 8 * TABLE_BYTES;
  localparam int unsigned LEN_W       = 4;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] CMD_UP     = 8'h01;
  localparam logic [7:0] CMD_DOWN   = 8'h02;
  localparam logic [7:0] CMD_CFG    = 8'h03;
  localparam logic [7:0] CMD_COMMIT = 8'h04;

  localparam logic [LEN_W-1:0] LEN_UP     = 4'd10;
  localparam logic [LEN_W-1:0] LEN_DOWN   = 4'd10;
  localparam logic [LEN_W-1:0] LEN_CFG    = 4'd6;
  localparam logic [LEN_W-1:0] LEN_COMMIT = 4'd0;

  localparam logic [7:0] ACK_CODE = 8'h06;
  localparam logic [7:0] NAK_CODE = 8'h15;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_CMD  = 2'd1,
    S_PAY  = 2'd2,
    S_CHK  = 2'd3
  } state_e;

  typedef struct packed {
    logic [TABLE_W-1:0] up;
    logic [TABLE_W-1:0] down;
    logic [7:0]         up_states;
    logic [7:0]         down_states;
    logic [7:0]         idle;
    logic [15:0]        divider;
    logic               en;
    logic               set;
  } cfg_t;

  function automatic cfg_t cfg_reset();
    cfg_t c;
    c.up          = '0;
    c.down        = '0;
    c.up_states   = 8'd10;
    c.down_states = 8'd10;
    c.idle        = 8'h80;
    c.divider     = 16'd1;
    c.en          = 1'b0;
    c.set         = 1'b0;
    return c;
  endfunction

  function automatic logic cmd_known(input logic [7:0] cmd);
    return cmd inside {CMD_UP, CMD_DOWN, CMD_CFG, CMD_COMMIT};
  endfunction

  function automatic logic [LEN_W-1:0] cmd_len(input logic [7:0] cmd);
    case (cmd)
      CMD_UP:   return LEN_UP;
      CMD_DOWN: return LEN_DOWN;
      CMD_CFG:  return LEN_CFG;
      default:  return LEN_COMMIT;
    endcase
  endfunction

endpackage

// File: rtl/dac_pattern_loader_byte_timeout.sv
// Inter-byte watchdog: counts while enabled, clears on each byte, flags expiry at TIMEOUT_CYCLES-1.
module byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired_c = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (!expired_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_pattern_loader.sv
// Framed command parser that fills shadow pattern/config registers and commits them to the sequencer.
// Define DAC_LOADER_ACK_EN to add the tx acknowledge channel (0x06 accepted / 0x15 rejected).
module dac_pattern_loader
  import dac_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned MAX_STATES     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [TABLE_W-1:0] up,
  output logic [TABLE_W-1:0] down,
  output logic [7:0]         up_states,
  output logic [7:0]         down_states,
  output logic [7:0]         idle,
  output logic [15:0]        divider,
  output logic               en,
  output logic               set,
  output logic               busy,
`ifdef DAC_LOADER_ACK_EN
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
`endif
  output logic               frame_ok,
  output logic               frame_err
);

  state_e             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [7:0]         xor_q, xor_d;
  logic [TABLE_W-1:0] buf_q, buf_d;
  cfg_t               shadow_q, shadow_d;
  cfg_t               active_q, active_d;
  logic               frame_ok_q, frame_ok_d;
  logic               frame_err_q, frame_err_d;
  logic               busy_q, busy_d;
  logic               expired_c;
  logic               chk_pass_c;
  logic               cfg_ok_c;

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr      (rx_valid),
    .en       (state_q != S_SYNC),
    .expired_c(expired_c)
  );

  // CFG payload layout: up_states, down_states, idle, div_hi, div_lo, flags
  assign chk_pass_c = ((xor_q ^ rx_data) == 8'h00);
  assign cfg_ok_c   = (buf_q[7:0]   >= 8'd1) && (buf_q[7:0]   <= 8'(MAX_STATES)) &&
                      (buf_q[15:8]  >= 8'd1) && (buf_q[15:8]  <= 8'(MAX_STATES)) &&
                      ({buf_q[31:24], buf_q[39:32]} != 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SYNC;
      cmd_q       <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      xor_q       <= '0;
      buf_q       <= '0;
      shadow_q    <= cfg_reset();
      active_q    <= cfg_reset();
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      xor_q       <= xor_d;
      buf_q       <= buf_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and frame-collection datapath
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    xor_d   = xor_q;
    buf_d   = buf_q;
    if (rx_valid) begin
      case (state_q)
        S_SYNC: begin
          if (rx_data == SYNC_BYTE) state_d = S_CMD;
        end
        S_CMD: begin
          cmd_d = rx_data;
          xor_d = rx_data;
          idx_d = '0;
          rem_d = cmd_len(rx_data);
          if (!cmd_known(rx_data))               state_d = S_SYNC;
          else if (cmd_len(rx_data) == LEN_COMMIT) state_d = S_CHK;
          else                                   state_d = S_PAY;
        end
        S_PAY: begin
          for (int unsigned k = 0; k < TABLE_BYTES; k++) begin
            if (idx_q == LEN_W'(k)) buf_d[8*k +: 8] = rx_data;
          end
          idx_d = idx_q + LEN_W'(1);
          rem_d = rem_q - LEN_W'(1);
          xor_d = xor_q ^ rx_data;
          if (rem_q == LEN_W'(1)) state_d = S_CHK;
        end
        default: state_d = S_SYNC;
      endcase
    end else if (expired_c) begin
      state_d = S_SYNC;
    end
  end

  // Frame verdict, shadow update and commit
  always_comb begin
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    shadow_d    = shadow_q;
    active_d    = active_q;
    if (rx_valid) begin
      if (state_q == S_CMD && !cmd_known(rx_data)) begin
        frame_err_d = 1'b1;
      end else if (state_q == S_CHK) begin
        if (!chk_pass_c || (cmd_q == CMD_CFG && !cfg_ok_c)) begin
          frame_err_d = 1'b1;
        end else begin
          frame_ok_d = 1'b1;
          case (cmd_q)
            CMD_UP:   shadow_d.up   = buf_q;
            CMD_DOWN: shadow_d.down = buf_q;
            CMD_CFG: begin
              shadow_d.up_states   = buf_q[7:0];
              shadow_d.down_states = buf_q[15:8];
              shadow_d.idle        = buf_q[23:16];
              shadow_d.divider     = {buf_q[31:24], buf_q[39:32]};
              shadow_d.en          = buf_q[40];
              shadow_d.set         = buf_q[41];
            end
            default:  active_d = shadow_q;
          endcase
        end
      end
    end else if (expired_c) begin
      frame_err_d = 1'b1;
    end
    busy_d = (state_d != S_SYNC);
  end

  assign up          = active_q.up;
  assign down        = active_q.down;
  assign up_states   = active_q.up_states;
  assign down_states = active_q.down_states;
  assign idle        = active_q.idle;
  assign divider     = active_q.divider;
  assign en          = active_q.en;
  assign set         = active_q.set;
  assign busy        = busy_q;
  assign frame_ok    = frame_ok_q;
  assign frame_err   = frame_err_q;

`ifdef DAC_LOADER_ACK_EN
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;

  // Latest verdict wins over a response the host has not yet taken
  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
    if (frame_ok_d) begin
      tx_data_d  = ACK_CODE;
      tx_valid_d = 1'b1;
    end else if (frame_err_d) begin
      tx_data_d  = NAK_CODE;
      tx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
`endif

endmodule
